// File: rtl/frame_sched.sv
// -----------------------------------------------------------------------------
// frame_sched
//   Frame scheduler for the audio capture path. A divider turns clk_in into a
//   one-cycle frame_tick, not a derived clock. Each tick starts one capture
//   into cap_slot. When the capture engine reports cap_done, the frame is
//   committed to the display slot. The next capture slot is then chosen so that
//   it never collides with the slot on display.
//
// Ports
//   clk_in       in   1       system clock
//   rst          in   1       asynchronous, active-low reset
//   en           in   1       scheduling enable (level)
//   freeze       in   1       1 = hold the displayed slot, capture continues
//   clr_overrun  in   1       pulse, clears the sticky overrun flag
//   cap_done     in   1       pulse from the capture engine: frame written
//   frame_tick   out  1       one-cycle pulse every DIV cycles while en=1
//   cap_start    out  1       one-cycle pulse starting a capture into cap_slot
//   cap_slot     out  SLOT_W  slot being written by the capture engine
//   disp_slot    out  SLOT_W  last committed slot, for display
//   disp_valid   out  1       at least one frame has been committed
//   overrun      out  1       sticky: tick arrived while a capture was running
//   state        out  2       IDLE=0, ARM=1, CAPTURE=2, COMMIT=3
// -----------------------------------------------------------------------------
module frame_sched #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int FRAME_HZ  = 2,
  parameter int NUM_SLOTS = 4,
  parameter int SLOT_W    = 2,
  parameter int CNT_W     = 26
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              en,
  input  logic              freeze,
  input  logic              clr_overrun,
  input  logic              cap_done,
  output logic              frame_tick,
  output logic              cap_start,
  output logic [SLOT_W-1:0] cap_slot,
  output logic [SLOT_W-1:0] disp_slot,
  output logic              disp_valid,
  output logic              overrun,
  output logic [1:0]        state
);

  localparam int                DIV       = CLK_HZ / FRAME_HZ;
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [SLOT_W-1:0] SLOT_MAX  = SLOT_W'(NUM_SLOTS - 1);
  localparam logic [SLOT_W-1:0] SLOT_ZERO = {SLOT_W{1'b0}};
  localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_COMMIT  = 2'd3
  } state_t;

  // Slot increment modulo NUM_SLOTS; NUM_SLOTS need not be a power of two.
  function automatic logic [SLOT_W-1:0] slot_inc(input logic [SLOT_W-1:0] s);
    if (s == SLOT_MAX) begin
      return SLOT_ZERO;
    end else begin
      return s + SLOT_ONE;
    end
  endfunction

  logic [CNT_W-1:0]  cnt_r;
  logic              tick_r;
  state_t            state_r,      state_s;
  logic              cap_start_r,  cap_start_s;
  logic [SLOT_W-1:0] cap_slot_r,   cap_slot_s;
  logic [SLOT_W-1:0] disp_slot_r,  disp_slot_s;
  logic              disp_valid_r, disp_valid_s;
  logic              overrun_r,    overrun_s;
  logic [SLOT_W-1:0] commit_disp_s;
  logic [SLOT_W-1:0] commit_cap_s;

  // Frame divider: counts 0..DIV-1 while enabled, tick registered after the wrap.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      cnt_r  <= CNT_ZERO;
      tick_r <= 1'b0;
    end else if (!en) begin
      cnt_r  <= CNT_ZERO;
      tick_r <= 1'b0;
    end else if (cnt_r == CNT_MAX) begin
      cnt_r  <= CNT_ZERO;
      tick_r <= 1'b1;
    end else begin
      cnt_r  <= cnt_r + CNT_ONE;
      tick_r <= 1'b0;
    end
  end

  // Commit slot selection: the display takes the captured slot unless frozen.
  // The next capture slot skips whatever ends up on display.
  always_comb begin
    commit_disp_s = freeze ? disp_slot_r : cap_slot_r;
    commit_cap_s  = slot_inc(cap_slot_r);
    if (commit_cap_s == commit_disp_s) begin
      commit_cap_s = slot_inc(commit_cap_s);
    end else begin
      commit_cap_s = commit_cap_s;
    end
  end

  // Scheduler next-state and next-output logic.
  always_comb begin
    state_s      = state_r;
    cap_start_s  = 1'b0;
    cap_slot_s   = cap_slot_r;
    disp_slot_s  = disp_slot_r;
    disp_valid_s = disp_valid_r;
    // Clear is applied first so a simultaneous new overrun below wins.
    overrun_s    = clr_overrun ? 1'b0 : overrun_r;

    case (state_r)
      ST_IDLE: begin
        if (en) begin
          state_s = ST_ARM;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ARM: begin
        if (!en) begin
          state_s = ST_IDLE;
        end else if (tick_r) begin
          state_s     = ST_CAPTURE;
          cap_start_s = 1'b1;
        end else begin
          state_s = ST_ARM;
        end
      end
      ST_CAPTURE: begin
        // en is deliberately ignored here: a started frame always completes.
        if (cap_done) begin
          state_s = ST_COMMIT;
        end else if (tick_r) begin
          overrun_s = 1'b1;
        end else begin
          state_s = ST_CAPTURE;
        end
      end
      ST_COMMIT: begin
        disp_slot_s = commit_disp_s;
        if (!freeze) begin
          disp_valid_s = 1'b1;
        end else begin
          disp_valid_s = disp_valid_r;
        end
        cap_slot_s = commit_cap_s;
        state_s    = en ? ST_ARM : ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Scheduler state and registered outputs.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      cap_start_r  <= 1'b0;
      cap_slot_r   <= SLOT_ZERO;
      disp_slot_r  <= SLOT_ZERO;
      disp_valid_r <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      state_r      <= state_s;
      cap_start_r  <= cap_start_s;
      cap_slot_r   <= cap_slot_s;
      disp_slot_r  <= disp_slot_s;
      disp_valid_r <= disp_valid_s;
      overrun_r    <= overrun_s;
    end
  end

  assign frame_tick = tick_r;
  assign cap_start  = cap_start_r;
  assign cap_slot   = cap_slot_r;
  assign disp_slot  = disp_slot_r;
  assign disp_valid = disp_valid_r;
  assign overrun    = overrun_r;
  assign state      = state_r;

endmodule

// File: tb/tb_frame_sched.sv
// -----------------------------------------------------------------------------
// tb_frame_sched
//   Self-checking bench for frame_sched with CLK_HZ=20, FRAME_HZ=2 (DIV=10)
//   and NUM_SLOTS=3. Commit results are pushed to a scoreboard queue when
//   cap_done is driven and popped when the committed values become visible.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_frame_sched;

  localparam int DIV = 10;

  logic       clk_in;
  logic       rst;
  logic       en;
  logic       freeze;
  logic       clr_overrun;
  logic       cap_done;
  logic       frame_tick;
  logic       cap_start;
  logic [1:0] cap_slot;
  logic [1:0] disp_slot;
  logic       disp_valid;
  logic       overrun;
  logic [1:0] state;

  frame_sched #(
    .CLK_HZ   (20),
    .FRAME_HZ (2),
    .NUM_SLOTS(3),
    .SLOT_W   (2),
    .CNT_W    (4)
  ) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .en         (en),
    .freeze     (freeze),
    .clr_overrun(clr_overrun),
    .cap_done   (cap_done),
    .frame_tick (frame_tick),
    .cap_start  (cap_start),
    .cap_slot   (cap_slot),
    .disp_slot  (disp_slot),
    .disp_valid (disp_valid),
    .overrun    (overrun),
    .state      (state)
  );

  typedef struct {
    logic       freeze;
    logic [1:0] cap_before;
    logic [1:0] disp;
    logic [1:0] cap_after;
    logic       valid;
  } frame_vec_t;

  typedef struct {
    logic [1:0] disp;
    logic [1:0] cap;
    logic       valid;
  } exp_t;

  frame_vec_t vecs[8];
  exp_t       sb[$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         last_tick_cyc = 0;
  int         tick_cnt;

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk_in);
    #1;
    cyc++;
  endtask

  // Waits (bounded) for the next frame_tick and checks the tick period.
  task automatic wait_tick(input string nm);
    int n;
    n = 0;
    do begin
      cycle();
      n++;
    end while (frame_tick !== 1'b1 && n < 40);
    chk({nm, "_tick_seen"}, 32'(frame_tick), 32'd1);
    chk({nm, "_tick_period"}, 32'(cyc - last_tick_cyc), 32'(DIV));
    last_tick_cyc = cyc;
  endtask

  // Drives cap_done now, expects COMMIT next cycle and results the cycle after.
  task automatic do_commit(input string nm, input logic frz, input logic [1:0] ed,
                           input logic [1:0] ec, input logic ev);
    exp_t e;
    exp_t got;
    freeze   = frz;
    cap_done = 1'b1;
    e.disp = ed; e.cap = ec; e.valid = ev;
    sb.push_back(e);
    cycle();
    cap_done = 1'b0;
    chk({nm, "_state_commit"}, 32'(state), 32'd3);
    cycle();
    if (sb.size() == 0) begin
      chk({nm, "_sb_nonempty"}, 32'd0, 32'd1);
    end else begin
      got = sb.pop_front();
      chk({nm, "_disp_slot"}, 32'(disp_slot), 32'(got.disp));
      chk({nm, "_cap_slot"}, 32'(cap_slot), 32'(got.cap));
      chk({nm, "_disp_valid"}, 32'(disp_valid), 32'(got.valid));
    end
  endtask

  initial begin
    // freeze, cap_before, disp, cap_after, valid
    vecs[0] = '{1'b0, 2'd0, 2'd0, 2'd1, 1'b1};
    vecs[1] = '{1'b0, 2'd1, 2'd1, 2'd2, 1'b1};
    vecs[2] = '{1'b0, 2'd2, 2'd2, 2'd0, 1'b1};
    vecs[3] = '{1'b0, 2'd0, 2'd0, 2'd1, 1'b1};
    vecs[4] = '{1'b0, 2'd1, 2'd1, 2'd2, 1'b1};
    vecs[5] = '{1'b1, 2'd2, 2'd1, 2'd0, 1'b1};
    vecs[6] = '{1'b1, 2'd0, 2'd1, 2'd2, 1'b1};
    vecs[7] = '{1'b0, 2'd2, 2'd2, 2'd0, 1'b1};

    rst = 1'b0; en = 1'b0; freeze = 1'b0; clr_overrun = 1'b0; cap_done = 1'b0;
    repeat (3) cycle();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_cap_slot", 32'(cap_slot), 32'd0);
    chk("rst_disp_slot", 32'(disp_slot), 32'd0);
    chk("rst_disp_valid", 32'(disp_valid), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_tick", 32'(frame_tick), 32'd0);
    chk("rst_cap_start", 32'(cap_start), 32'd0);

    // Normal frames, slot rotation with wrap, and freeze behaviour.
    rst = 1'b1; en = 1'b1;
    last_tick_cyc = cyc;
    for (int i = 0; i < 8; i++) begin
      wait_tick($sformatf("f%0d", i));
      cycle();
      chk($sformatf("f%0d_cap_start", i), 32'(cap_start), 32'd1);
      chk($sformatf("f%0d_cap_slot_start", i), 32'(cap_slot), 32'(vecs[i].cap_before));
      chk($sformatf("f%0d_state_capture", i), 32'(state), 32'd2);
      cycle();
      chk($sformatf("f%0d_cap_start_pulse", i), 32'(cap_start), 32'd0);
      cycle();
      cycle();
      do_commit($sformatf("f%0d", i), vecs[i].freeze, vecs[i].disp,
                vecs[i].cap_after, vecs[i].valid);
      chk($sformatf("f%0d_state_arm", i), 32'(state), 32'd1);
    end
    freeze = 1'b0;

    // Overrun: withhold cap_done past the next tick.
    wait_tick("ovr_a");
    cycle();
    chk("ovr_cap_start", 32'(cap_start), 32'd1);
    wait_tick("ovr_b");
    cycle();
    chk("ovr_set", 32'(overrun), 32'd1);
    chk("ovr_state", 32'(state), 32'd2);
    chk("ovr_no_restart", 32'(cap_start), 32'd0);
    wait_tick("ovr_c");
    clr_overrun = 1'b1;
    cycle();
    clr_overrun = 1'b0;
    chk("ovr_set_wins", 32'(overrun), 32'd1);
    do_commit("ovr", 1'b0, 2'd0, 2'd1, 1'b1);
    clr_overrun = 1'b1;
    cycle();
    clr_overrun = 1'b0;
    chk("ovr_cleared", 32'(overrun), 32'd0);

    // Tick and cap_done in the same cycle: commit without overrun.
    wait_tick("same_a");
    cycle();
    chk("same_cap_slot", 32'(cap_slot), 32'd1);
    wait_tick("same_b");
    do_commit("same", 1'b0, 2'd1, 2'd2, 1'b1);
    chk("same_no_overrun", 32'(overrun), 32'd0);

    // en dropped mid-capture: frame still commits, then IDLE, no ticks.
    wait_tick("en_a");
    cycle();
    chk("en_cap_slot", 32'(cap_slot), 32'd2);
    en = 1'b0;
    repeat (3) cycle();
    chk("en_wait_capture", 32'(state), 32'd2);
    do_commit("en", 1'b0, 2'd2, 2'd0, 1'b1);
    chk("en_idle", 32'(state), 32'd0);
    tick_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      cap_done = (i == 4) ? 1'b1 : 1'b0;
      cycle();
      if (frame_tick === 1'b1) tick_cnt++;
    end
    cap_done = 1'b0;
    chk("idle_no_ticks", 32'(tick_cnt), 32'd0);
    chk("idle_done_ignored_disp", 32'(disp_slot), 32'd2);
    chk("idle_done_ignored_cap", 32'(cap_slot), 32'd0);
    chk("idle_state", 32'(state), 32'd0);

    // en dropped while armed.
    en = 1'b1;
    cycle();
    chk("arm_entered", 32'(state), 32'd1);
    en = 1'b0;
    cycle();
    chk("arm_to_idle", 32'(state), 32'd0);

    // Asynchronous reset in the middle of a capture.
    en = 1'b1;
    last_tick_cyc = cyc;
    wait_tick("rst_mid");
    cycle();
    chk("rstm_cap_start", 32'(cap_start), 32'd1);
    cycle();
    #2;
    rst = 1'b0;
    #1;
    chk("rstm_state", 32'(state), 32'd0);
    chk("rstm_cap_slot", 32'(cap_slot), 32'd0);
    chk("rstm_disp_slot", 32'(disp_slot), 32'd0);
    chk("rstm_disp_valid", 32'(disp_valid), 32'd0);
    chk("rstm_overrun", 32'(overrun), 32'd0);
    chk("rstm_cap_start0", 32'(cap_start), 32'd0);
    chk("rstm_tick", 32'(frame_tick), 32'd0);
    rst = 1'b1;
    cap_done = 1'b1;
    cycle();
    cap_done = 1'b0;
    chk("late_done_state", 32'(state), 32'd1);
    chk("late_done_valid", 32'(disp_valid), 32'd0);
    chk("late_done_disp", 32'(disp_slot), 32'd0);
    cycle();
    chk("late_done_state2", 32'(state), 32'd1);

    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
